seg7_scan_mux: RTL and testbench

//  Downstream display stage for the seconds counter: time-multiplexes NUM_DIGITS BCD digits

---
 rtl/seg7_scan_mux_pkg.sv | 11 +
 rtl/seg7_scan_mux_seg7.sv | 26 ++
 rtl/seg7_scan_mux.sv | 135 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the 7-segment scan multiplexer: blank segment pattern and scan FSM states.
package seg7_scan_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_mux_seg7.sv
// BCD to 7-segment decoder {g,f,e,d,c,b,a}, active high; purely combinational.
module seg7
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] i_counter,
  output logic [6:0] o_segments
);

  always_comb begin
    o_segments = SEG_BLANK;
    case (i_counter)
      4'd0: o_segments = 7'b011_1111;
      4'd1: o_segments = 7'b000_0110;
      4'd2: o_segments = 7'b101_1011;
      4'd3: o_segments = 7'b100_1111;
      4'd4: o_segments = 7'b110_0110;
      4'd5: o_segments = 7'b110_1101;
      4'd6: o_segments = 7'b111_1101;
      4'd7: o_segments = 7'b000_0111;
      4'd8: o_segments = 7'b111_1111;
      4'd9: o_segments = 7'b110_1111;
      default: o_segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one 7-segment bus with per-slot blanking.
// Outputs are registered one cycle behind the scan state; new digits take effect only at frame start.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 10_000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                  r_state;
  logic [CNT_W-1:0]             r_slot_cnt;
  logic [IDX_W-1:0]             r_index;
  logic [NUM_DIGITS-1:0][3:0]   r_shadow_dig;
  logic [NUM_DIGITS-1:0][3:0]   r_active_dig;
  logic [NUM_DIGITS-1:0]        r_shadow_dp;
  logic [NUM_DIGITS-1:0]        r_active_dp;
  logic [6:0]                   r_seg;
  logic                         r_dp;
  logic [NUM_DIGITS-1:0]        r_digit_en;
  logic                         r_frame_done;

  logic                         w_slot_last;
  logic                         w_idx_last;
  logic                         w_promote;
  logic [3:0]                   w_digit;
  logic [6:0]                   w_dec_seg;
  logic [6:0]                   w_seg;
  logic [NUM_DIGITS-1:0]        w_lz_mask;
  logic                         w_upper_zero;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);
  assign w_idx_last  = (r_index == IDX_LAST);
  assign w_promote   = ena & w_slot_last & w_idx_last;
  assign w_digit     = r_active_dig[r_index];

  seg7 u_seg7 (
    .i_counter  (w_digit),
    .o_segments (w_dec_seg)
  );

  // A digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    w_lz_mask    = '0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero & (r_active_dig[k] == 4'd0);
      w_lz_mask[k] = blank_lz & w_upper_zero;
    end
  end

  assign w_seg = w_lz_mask[r_index] ? SEG_BLANK : w_dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_slot_cnt   <= '0;
      r_index      <= '0;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else if (!ena) begin
      r_state      <= ST_BLANK;
      r_slot_cnt   <= '0;
      r_index      <= '0;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_state    <= ST_BLANK;
        r_index    <= w_idx_last ? '0 : r_index + 1'b1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
        if (r_slot_cnt == BLANK_LAST) r_state <= ST_SHOW;
      end
      r_frame_done <= w_promote;
      if (r_state == ST_SHOW) begin
        r_digit_en <= NUM_DIGITS'(1) << r_index;
        r_seg      <= w_seg;
        r_dp       <= r_active_dp[r_index];
      end else begin
        r_digit_en <= '0;
        r_seg      <= SEG_BLANK;
        r_dp       <= 1'b0;
      end
    end
  end

  // A load coinciding with the promote lands in shadow only; active takes the previous shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_active_dig <= '0;
      r_active_dp  <= '0;
    end else begin
      if (load) begin
        r_shadow_dig <= digits_in;
        r_shadow_dp  <= dp_in;
      end
      if (w_promote) begin
        r_active_dig <= r_shadow_dig;
        r_active_dp  <= r_shadow_dp;
      end
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with 4 digits, 8-cycle slots and 2 blank cycles per slot.
module tb_seg7_scan_mux;

  localparam logic [6:0] SB = 7'b000_0000;
  localparam logic [6:0] S0 = 7'b011_1111;
  localparam logic [6:0] S1 = 7'b000_0110;
  localparam logic [6:0] S2 = 7'b101_1011;
  localparam logic [6:0] S3 = 7'b100_1111;
  localparam logic [6:0] S4 = 7'b110_0110;
  localparam logic [6:0] S5 = 7'b110_1101;
  localparam logic [6:0] S6 = 7'b111_1101;
  localparam logic [6:0] S7 = 7'b000_0111;
  localparam logic [6:0] S8 = 7'b111_1111;
  localparam logic [6:0] S9 = 7'b110_1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs [8];

  seg7_scan_mux #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {digit_en, seg_out, dp_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    bit found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_frame_done: no pulse within 80 cycles, expected one");
    end
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  initial begin
    int cnt;
    int blanks;
    int multi;

    vecs[0] = '{digits: 16'h1234, dp: 4'b0000, lz: 1'b0, seg: {S1, S2, S3, S4}};
    vecs[1] = '{digits: 16'h0070, dp: 4'b0000, lz: 1'b1, seg: {SB, SB, S7, S0}};
    vecs[2] = '{digits: 16'h0000, dp: 4'b0000, lz: 1'b1, seg: {SB, SB, SB, S0}};
    vecs[3] = '{digits: 16'h0000, dp: 4'b0000, lz: 1'b0, seg: {S0, S0, S0, S0}};
    vecs[4] = '{digits: 16'h000B, dp: 4'b0001, lz: 1'b0, seg: {S0, S0, S0, SB}};
    vecs[5] = '{digits: 16'h5678, dp: 4'b1010, lz: 1'b1, seg: {S5, S6, S7, S8}};
    vecs[6] = '{digits: 16'h0905, dp: 4'b0100, lz: 1'b1, seg: {SB, S9, S0, S5}};
    vecs[7] = '{digits: 16'h00C0, dp: 4'b0011, lz: 1'b1, seg: {SB, SB, SB, S0}};

    rst_n = 1'b0; ena = 1'b1; digits_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    #12;
    check("reset_outputs", {19'd0, obs(), frame_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step(2);
    check("first_blank", {28'd0, digit_en}, 32'h0);
    step(1);
    check("first_digit0", {20'd0, obs()}, {20'd0, 4'b0001, S0, 1'b0});

    // Frame period, blank count and one-hot enables over one whole frame
    wait_fd();
    cnt = 0; blanks = 0; multi = 0;
    do begin
      step(1);
      cnt++;
      if (digit_en == 4'b0000) blanks++;
      if ($countones(digit_en) > 1) multi++;
    end while (!frame_done && cnt < 100);
    check("frame_period", cnt, 32);
    check("blank_cycles_per_frame", blanks, 8);
    check("multi_hot", multi, 0);
    step(1);
    check("frame_done_single", {31'd0, frame_done}, 32'd0);

    // Reset asserted mid-SHOW clears outputs asynchronously
    wait_fd();
    step(4);
    check("pre_reset_show", {28'd0, digit_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {19'd0, obs(), frame_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step(2);
    check("post_reset_blank", {28'd0, digit_en}, 32'h0);
    step(1);
    check("post_reset_digit0", {20'd0, obs()}, {20'd0, 4'b0001, S0, 1'b0});

    for (int v = 0; v < 8; v++) begin
      wait_fd();
      step(5);
      blank_lz = vecs[v].lz;
      load_val(vecs[v].digits, vecs[v].dp);
      wait_fd();
      step(3);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("vec%0d_digit%0d", v, k), {20'd0, obs()},
              {20'd0, 4'(1 << k), vecs[v].seg[k], vecs[v].dp[k]});
        if (k < 3) step(8);
      end
    end

    // Tear-free update and load coincident with the promote
    blank_lz = 1'b0;
    wait_fd();
    step(5);
    load_val(16'h1234, 4'b0000);
    wait_fd();
    step(12);
    load_val(16'h5678, 4'b0000);
    step(6);
    check("tear_digit2_old", {20'd0, obs()}, {20'd0, 4'b0100, S2, 1'b0});
    step(8);
    check("tear_digit3_old", {20'd0, obs()}, {20'd0, 4'b1000, S1, 1'b0});
    step(4);
    digits_in = 16'h9999; dp_in = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    check("coincident_frame_done", {31'd0, frame_done}, 32'd1);
    step(3);
    check("next_frame_digit0", {20'd0, obs()}, {20'd0, 4'b0001, S8, 1'b0});
    step(8);
    check("next_frame_digit1", {20'd0, obs()}, {20'd0, 4'b0010, S7, 1'b0});
    wait_fd();
    step(3);
    check("late_frame_digit0", {20'd0, obs()}, {20'd0, 4'b0001, S9, 1'b0});

    // Enable dropped mid slot 2, then restored
    wait_fd();
    step(20);
    check("ena_pre_slot2", {20'd0, obs()}, {20'd0, 4'b0100, S9, 1'b0});
    ena = 1'b0;
    step(1);
    check("ena_low_outputs", {19'd0, obs(), frame_done}, 32'd0);
    step(5);
    check("ena_low_hold", {19'd0, obs(), frame_done}, 32'd0);
    ena = 1'b1;
    step(2);
    check("ena_rise_blank", {28'd0, digit_en}, 32'h0);
    step(1);
    check("ena_rise_digit0", {20'd0, obs()}, {20'd0, 4'b0001, S9, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
